bpu_update_queue: RTL and testbench
===================================

BPU_UPDATE_QUEUE -- requirements
Module: bpu_update_queue

Interface
REQ-001 The block SHALL expose parameter IDX_W, default 8, meaning the PHT index width (equal to the predictor's GHR width).
REQ-002 The block SHALL expose parameter DEPTH, default 4, meaning the number of queue entries (power of two, at least 2).
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 The block SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port res_valid  input  1  resolved-branch update offered this cycle.
REQ-006 The block SHALL have port res_index  input  IDX_W  PHT index carried down the pipeline from prediction time.
REQ-007 The block SHALL have port res_take  input  1  actual branch direction.
REQ-008 The block SHALL have port res_ready  output  1  the queue can accept an update this cycle.
REQ-009 The block SHALL have port freeze  input  1  inhibits draining to the predictor write port.
REQ-010 The block SHALL have port wen  output  1  predictor write enable.
REQ-011 The block SHALL have port write_index  output  IDX_W  predictor write index.
REQ-012 The block SHALL have port take  output  1  predictor write direction.
REQ-013 The block SHALL have port lookup_index  input  IDX_W  index currently being predicted.
REQ-014 The block SHALL have port pending_hit  output  1  a queued, unwritten update targets lookup_index.
REQ-015 The block SHALL have port pending_take  output  1  direction of the youngest matching queued update.
REQ-016 The block SHALL have port drop_cnt  output  8  saturating count of updates lost to overflow.

Function
REQ-017 The queue SHALL be a circular FIFO of DEPTH entries {index, take}, with read/write pointers of log2(DEPTH)+1 bits wrapping modulo 2*DEPTH.
REQ-018 res_ready SHALL be !full, where full is computed from registered state only (no same-cycle dequeue credit).
REQ-019 An enqueue SHALL occur when res_valid && res_ready.
REQ-020 When res_valid && !res_ready, the update SHALL be discarded and drop_cnt SHALL increment, saturating at 255.
REQ-021 wen SHALL equal !empty && !freeze, with write_index/take driven combinationally from the head entry; a dequeue occurs whenever wen=1.
REQ-022 Minimum latency SHALL be 1 cycle: an update enqueued at edge N produces wen=1 in the cycle after edge N, provided freeze=0.
REQ-023 Simultaneous enqueue and dequeue SHALL be permitted when not full; the occupancy is unchanged.
REQ-024 Updates SHALL reach the predictor strictly in enqueue order, one per cycle, with no duplication or loss other than per REQ-020.
REQ-025 While freeze=1, the contents SHALL be held and enqueue SHALL continue until full.
REQ-026 When empty, write_index and take SHALL be 0.

Reset
REQ-027 When resetn=0 at a clock edge, the pointers SHALL clear (queue empty) and drop_cnt SHALL clear.
REQ-028 Reset values SHALL be res_ready=1, wen=0, write_index=0, take=0, pending_hit=0, pending_take=0, drop_cnt=0.
REQ-029 Entries in flight at reset SHALL be discarded, and no wen SHALL be issued in the cycle after a reset edge.
REQ-030 Entry storage SHALL need no reset; only the pointers qualify validity.

Configuration
REQ-031 Macro BPQ_BYPASS_EN SHALL control pending-update lookup.
REQ-032 With BPQ_BYPASS_EN defined, pending_hit SHALL be the OR over all valid entries of (entry.index == lookup_index).
REQ-033 With BPQ_BYPASS_EN defined, pending_take SHALL be the take bit of the youngest valid matching entry, or 0 when there is no hit.
REQ-034 The lookup SHALL include the head entry even when it is being dequeued this cycle, and SHALL exclude res_* of the same cycle.
REQ-035 Without BPQ_BYPASS_EN, pending_hit and pending_take SHALL be tied to 0, with no comparators synthesised.

Verification
REQ-036 The bench SHALL cover: reset; single update idx=0x3C take=1 at cycle 0 -> wen=1, write_index=0x3C, take=1 at cycle 1; empty afterwards.
REQ-037 The bench SHALL cover: freeze=1, five updates idx 1..5 -> first four accepted, res_ready=0 after the 4th, 5th dropped, drop_cnt=1; after freeze=0, wen for idx 1,2,3,4 on consecutive cycles.
REQ-038 The bench SHALL cover: continuous res_valid every cycle with freeze=0 -> wen every cycle after the first, occupancy stays 1, drop_cnt=0.
REQ-039 The bench SHALL cover BPQ_BYPASS_EN defined: queued (0x10,take=1) then (0x10,take=0), freeze=1, lookup_index=0x10 -> pending_hit=1, pending_take=0; lookup_index=0x11 -> pending_hit=0.
REQ-040 The bench SHALL cover: resetn=0 asserted with 3 entries queued -> next cycle wen=0, res_ready=1, drop_cnt=0.
REQ-041 The bench SHALL cover: 300 overflowing drops -> drop_cnt saturates at 255.

Source files
------------

// File: rtl/bpu_update_queue.sv
`default_nettype none
// ============================================================================
// Module  : bpu_update_queue
// Purpose : Small circular FIFO that buffers resolved-branch updates on their
//           way to the pattern-history-table write port. Updates are drained
//           one per cycle in arrival order unless 'freeze' is high. When the
//           queue is full, new updates are dropped and counted.
// Ports   : clk, resetn (synchronous, active-low)
//           res_valid/res_index/res_take -> res_ready     enqueue side
//           freeze -> wen/write_index/take                predictor write side
//           lookup_index -> pending_hit/pending_take      pending-update lookup
//           drop_cnt                                      saturating drop count
// Config  : BPQ_BYPASS_EN - when defined, enables the pending-update lookup.
//           When undefined, pending_hit/pending_take are tied to 0.
// Rev     : 1.0 - initial release
// ============================================================================
module bpu_update_queue #(
    parameter int IDX_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             res_valid,
    input  logic [IDX_W-1:0] res_index,
    input  logic             res_take,
    output logic             res_ready,
    input  logic             freeze,
    output logic             wen,
    output logic [IDX_W-1:0] write_index,
    output logic             take,
    input  logic [IDX_W-1:0] lookup_index,
    output logic             pending_hit,
    output logic             pending_take,
    output logic [7:0]       drop_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    // Entry storage carries no reset; validity comes only from the pointers.
    logic [IDX_W-1:0] idx_mem_q  [DEPTH];
    logic             take_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic             w_empty;
    logic             w_full;
    logic             w_enq;
    logic             w_deq;
    logic [PTR_W-1:0] w_count;

    // Extra pointer bit distinguishes full from empty when the slot bits match.
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_count = wr_ptr_q - rd_ptr_q;

    // Ready is based on registered state only: no credit for a same-cycle drain.
    assign res_ready = !w_full;
    assign w_enq     = res_valid && !w_full;
    assign w_deq     = !w_empty && !freeze;

    assign wen         = w_deq;
    assign write_index = w_empty ? '0   : idx_mem_q[rd_ptr_q[AW-1:0]];
    assign take        = w_empty ? 1'b0 : take_mem_q[rd_ptr_q[AW-1:0]];
    assign drop_cnt    = drop_cnt_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_cnt_d = drop_cnt_q;
        if (w_enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (res_valid && w_full && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            idx_mem_q[wr_ptr_q[AW-1:0]]  <= res_index;
            take_mem_q[wr_ptr_q[AW-1:0]] <= res_take;
        end
    end

`ifdef BPQ_BYPASS_EN
    // Walk valid entries oldest to youngest so the last match wins, giving the
    // youngest matching direction. The head is included even while draining;
    // this cycle's res_* inputs are not visible until they are stored.
    always_comb begin
        logic [AW-1:0] slot;
        pending_hit  = 1'b0;
        pending_take = 1'b0;
        slot         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr_q[AW-1:0] + AW'(k);
            if ((PTR_W'(k) < w_count) && (idx_mem_q[slot] == lookup_index)) begin
                pending_hit  = 1'b1;
                pending_take = take_mem_q[slot];
            end
        end
    end
`else
    logic lookup_unused;
    assign lookup_unused = ^{lookup_index, w_count};
    assign pending_hit   = 1'b0;
    assign pending_take  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bpu_update_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_bpu_update_queue
// Purpose : Directed self-checking bench for bpu_update_queue (IDX_W=8,
//           DEPTH=4). Each scenario task drives stimulus and checks inline.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_bpu_update_queue;

    logic       clk;
    logic       resetn;
    logic       res_valid;
    logic [7:0] res_index;
    logic       res_take;
    logic       res_ready;
    logic       freeze;
    logic       wen;
    logic [7:0] write_index;
    logic       take;
    logic [7:0] lookup_index;
    logic       pending_hit;
    logic       pending_take;
    logic [7:0] drop_cnt;

    int tests_run;
    int tests_failed;

    bpu_update_queue #(.IDX_W(8), .DEPTH(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .res_valid    (res_valid),
        .res_index    (res_index),
        .res_take     (res_take),
        .res_ready    (res_ready),
        .freeze       (freeze),
        .wen          (wen),
        .write_index  (write_index),
        .take         (take),
        .lookup_index (lookup_index),
        .pending_hit  (pending_hit),
        .pending_take (pending_take),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are read here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        res_valid = 1'b0;
        res_index = 8'h00;
        res_take  = 1'b0;
        freeze    = 1'b0;
        step();
        step();
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        lookup_index = 8'h00;
        do_reset();
        tests_run++;
        if ({res_ready, wen, write_index, take, pending_hit, pending_take, drop_cnt} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset_values: got rdy=%b wen=%b idx=%h take=%b ph=%b pt=%b drop=%0d, want 1 0 00 0 0 0 0",
                     res_ready, wen, write_index, take, pending_hit, pending_take, drop_cnt);
        end
    endtask

    task automatic test_single();
        res_valid = 1'b1;
        res_index = 8'h3C;
        res_take  = 1'b1;
        step();
        res_valid = 1'b0;
        res_index = 8'h00;
        res_take  = 1'b0;
        #1;
        tests_run++;
        if ({wen, write_index, take} !== {1'b1, 8'h3C, 1'b1}) begin
            tests_failed++;
            $display("FAIL single_latency: got wen=%b idx=%h take=%b, want 1 3c 1",
                     wen, write_index, take);
        end
        step();
        tests_run++;
        if ({wen, write_index, take} !== {1'b0, 8'h00, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_empty_after: got wen=%b idx=%h take=%b, want 0 00 0",
                     wen, write_index, take);
        end
    endtask

    task automatic test_freeze_overflow();
        freeze = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            res_valid = 1'b1;
            res_index = 8'(i);
            res_take  = i[0];
            #1;
            tests_run++;
            if (res_ready !== (i <= 4)) begin
                tests_failed++;
                $display("FAIL freeze_ready_%0d: got %b, want %b", i, res_ready, (i <= 4));
            end
            step();
        end
        res_valid = 1'b0;
        #1;
        tests_run++;
        if ({res_ready, wen, drop_cnt} !== {1'b0, 1'b0, 8'd1}) begin
            tests_failed++;
            $display("FAIL freeze_hold: got rdy=%b wen=%b drop=%0d, want 0 0 1",
                     res_ready, wen, drop_cnt);
        end
        freeze = 1'b0;
        #1;
        for (int i = 1; i <= 4; i++) begin
            tests_run++;
            if ({wen, write_index, take} !== {1'b1, 8'(i), i[0]}) begin
                tests_failed++;
                $display("FAIL drain_order_%0d: got wen=%b idx=%h take=%b, want 1 %h %b",
                         i, wen, write_index, take, 8'(i), i[0]);
            end
            step();
        end
        tests_run++;
        if ({wen, res_ready} !== {1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL drain_done: got wen=%b rdy=%b, want 0 1", wen, res_ready);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            res_valid = 1'b1;
            res_index = 8'h80 + 8'(k);
            res_take  = ~k[0];
            step();
            // Queue holds exactly the entry stored at this edge: occupancy 1.
            tests_run++;
            if ({wen, write_index, take, res_ready} !== {1'b1, 8'h80 + 8'(k), ~k[0], 1'b1}) begin
                tests_failed++;
                $display("FAIL b2b_%0d: got wen=%b idx=%h take=%b rdy=%b, want 1 %h %b 1",
                         k, wen, write_index, take, res_ready, 8'h80 + 8'(k), ~k[0]);
            end
        end
        res_valid = 1'b0;
        step();
        tests_run++;
        if ({wen, drop_cnt} !== {1'b0, 8'd0}) begin
            tests_failed++;
            $display("FAIL b2b_end: got wen=%b drop=%0d, want 0 0", wen, drop_cnt);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        freeze    = 1'b1;
        res_valid = 1'b1;
        res_index = 8'h10;
        res_take  = 1'b1;
        step();
        res_take  = 1'b0;
        step();
        res_valid    = 1'b0;
        lookup_index = 8'h10;
        #1;
        tests_run++;
`ifdef BPQ_BYPASS_EN
        if ({pending_hit, pending_take} !== {1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL bypass_hit_youngest: got ph=%b pt=%b, want 1 0", pending_hit, pending_take);
        end
`else
        if ({pending_hit, pending_take} !== {1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL bypass_disabled: got ph=%b pt=%b, want 0 0", pending_hit, pending_take);
        end
`endif
        lookup_index = 8'h11;
        #1;
        tests_run++;
        if ({pending_hit, pending_take} !== {1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL bypass_miss: got ph=%b pt=%b, want 0 0", pending_hit, pending_take);
        end
        // A same-cycle offer must not be visible to the lookup.
        res_valid = 1'b1;
        res_index = 8'h11;
        res_take  = 1'b1;
        #1;
        tests_run++;
        if (pending_hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL bypass_same_cycle: got ph=%b, want 0", pending_hit);
        end
        res_valid    = 1'b0;
        lookup_index = 8'h00;
        #1;
    endtask

    task automatic test_reset_flush();
        // Two entries are still queued and frozen; add a third.
        res_valid = 1'b1;
        res_index = 8'h22;
        res_take  = 1'b1;
        step();
        res_valid = 1'b0;
        // Produce a drop so the clear of drop_cnt is observable.
        res_valid = 1'b1;
        step();
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        #1;
        tests_run++;
        if ({res_ready, drop_cnt} !== {1'b0, 8'd1}) begin
            tests_failed++;
            $display("FAIL flush_setup: got rdy=%b drop=%0d, want 0 1", res_ready, drop_cnt);
        end
        resetn = 1'b0;
        freeze = 1'b0;
        step();
        resetn = 1'b1;
        #1;
        tests_run++;
        if ({wen, res_ready, drop_cnt, write_index} !== {1'b0, 1'b1, 8'd0, 8'h00}) begin
            tests_failed++;
            $display("FAIL flush_after_reset: got wen=%b rdy=%b drop=%0d idx=%h, want 0 1 0 00",
                     wen, res_ready, drop_cnt, write_index);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        freeze    = 1'b1;
        res_valid = 1'b1;
        res_index = 8'h5A;
        res_take  = 1'b0;
        for (int n = 1; n <= 304; n++) begin
            step();
            if (n == 258) begin
                tests_run++;
                if (drop_cnt !== 8'd254) begin
                    tests_failed++;
                    $display("FAIL sat_254: got %0d, want 254", drop_cnt);
                end
            end
            if (n == 259) begin
                tests_run++;
                if (drop_cnt !== 8'd255) begin
                    tests_failed++;
                    $display("FAIL sat_255: got %0d, want 255", drop_cnt);
                end
            end
        end
        res_valid = 1'b0;
        #1;
        tests_run++;
        if (drop_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL sat_hold: got %0d, want 255", drop_cnt);
        end
        freeze = 1'b0;
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single();
        test_freeze_overflow();
        test_back_to_back();
        test_bypass();
        test_reset_flush();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
